nibble_serial_add_ctrl: RTL and testbench

NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

---
 rtl/nibble_serial_add_ctrl.sv | 156 +++++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder/subtractor.
// One 4-bit slice is reused over NIBBLES cycles, LSB nibble first, to form a
// W-bit sum or difference. Subtraction is A + ~B + 1: B is inverted per nibble
// and the carry register is preloaded with sub on acceptance.
//
// Handshake: start is sampled only in IDLE. The result is valid while done=1
// and is held stable until ack=1 is sampled in DONE; the block then returns
// to IDLE on that edge. ack is ignored outside DONE. start is ignored outside
// IDLE, including when it coincides with ack.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   ack,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf,
  output logic [1:0]             state_dbg
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  // Slice signals
  logic [3:0]      nib_a;
  logic [3:0]      nib_b;
  logic [3:0]      low_sum;
  logic [1:0]      top_sum;
  logic [3:0]      slice_sum;
  logic            slice_c3;
  logic            slice_c4;
  logic            last_nib;

  assign last_nib = (idx_q == IW'(NIBBLES - 1));

  // 4-bit slice: carry into bit 3 is kept separately for signed overflow
  always_comb begin
    nib_a     = a_q[4*idx_q +: 4];
    nib_b     = b_q[4*idx_q +: 4] ^ {4{sub_q}};
    low_sum   = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, carry_q};
    slice_c3  = low_sum[3];
    top_sum   = {1'b0, nib_a[3]} + {1'b0, nib_b[3]} + {1'b0, slice_c3};
    slice_c4  = top_sum[1];
    slice_sum = {top_sum[0], low_sum[2:0]};
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)    state_d = S_RUN;
      S_RUN:   if (last_nib) state_d = S_DONE;
      S_DONE:  if (ack)      state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    result    = result_q;
    cout      = cout_q;
    ovf       = ovf_q;
    state_dbg = state_q;
  end

  // Datapath next values: operand capture on accept, one nibble per RUN cycle
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        result_d[4*idx_q +: 4] = slice_sum;
        carry_d                = slice_c4;
        idx_d                  = idx_q + IW'(1);
        if (last_nib) begin
          cout_d = slice_c4;
          ovf_d  = slice_c3 ^ slice_c4;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (NIBBLES=4, W=16).
// Inputs are driven on the falling edge; outputs are checked on the falling
// edge, half a cycle away from the active rising edge.
module tb_nibble_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         reset;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ack;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic [1:0]   state_dbg;

  int checks;
  int failures;

  // Expected results, pushed at issue and popped at done
  logic [W-1:0] exp_q[$];

  nibble_serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .state_dbg (state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, verify latency, result, hold behaviour and ack
  task automatic run_op(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] er, input logic ec, input logic eo,
                        input int hold);
    logic [W-1:0] exp_r;
    logic [W-1:0] r0;
    @(negedge clk);
    start = 1'b1; sub = s; a = av; b = bv;
    exp_q.push_back(er);
    @(negedge clk);
    // Operands change right after acceptance; they must not matter
    start = 1'b0; sub = ~s; a = ~av; b = av ^ bv;
    for (int i = 1; i <= N; i++) begin
      check($sformatf("done_early_c%0d", i), {63'd0, done}, 64'd0);
      check($sformatf("busy_run_c%0d", i), {63'd0, busy}, 64'd1);
      @(negedge clk);
    end
    check("done_latency", {63'd0, done}, 64'd1);
    exp_r = exp_q.pop_front();
    check("result", {48'd0, result}, {48'd0, exp_r});
    check("cout", {63'd0, cout}, {63'd0, ec});
    check("ovf", {63'd0, ovf}, {63'd0, eo});
    r0 = result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = a + 16'h1357; b = b ^ 16'hA5C3; sub = ~sub; ack = 1'b0;
      check("hold_done", {63'd0, done}, 64'd1);
      check("hold_result", {48'd0, result}, {48'd0, exp_r});
      check("hold_cout", {63'd0, cout}, {63'd0, ec});
      check("hold_ovf", {63'd0, ovf}, {63'd0, eo});
    end
    check("result_stable", {48'd0, result}, {48'd0, r0});
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("busy_after_ack", {63'd0, busy}, 64'd0);
    check("done_after_ack", {63'd0, done}, 64'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    start = 1'b0; sub = 1'b0; a = '0; b = '0; ack = 1'b0;
    reset = 1'b1;
    #12;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {48'd0, result}, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_ovf", {63'd0, ovf}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ack while idle must not do anything
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("idle_ack_busy", {63'd0, busy}, 64'd0);

    // Arithmetic vectors
    run_op(1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 0);
    run_op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 0);
    run_op(1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op(1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 0);

    // Hold done 10 cycles while inputs toggle
    run_op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 10);

    // start during RUN, and start together with ack in DONE, are ignored
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 16'h4444; b = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ign_done", {63'd0, done}, 64'd1);
    check("ign_result", {48'd0, result}, 64'h2345);
    check("ign_cout", {63'd0, cout}, 64'd0);
    start = 1'b1; ack = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    check("ign_busy_after_ack", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("ign_no_restart", {63'd0, busy}, 64'd0);

    // Asynchronous reset at index 2
    start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h1111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_result", {48'd0, result}, 64'd0);
    check("arst_cout", {63'd0, cout}, 64'd0);
    check("arst_ovf", {63'd0, ovf}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      check("arst_no_done", {63'd0, done}, 64'd0);
    end
    run_op(1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
